// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory/writeback stage.
// Holds the state encoding, the word byte-enable constant and the request decoder.
package mem_access_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_FAULT = 2'd3
  } mem_op_e;

  localparam logic [3:0] MEM_BE_WORD = 4'b1111;
  localparam int         MEM_TIMEOUT = 16;

  // Only whole-word, aligned, single-direction accesses are legal.
  function automatic mem_op_e decode_op(input logic [3:0] rden,
                                        input logic [3:0] wren,
                                        input logic [1:0] addr_lo);
    logic    rd_any;
    logic    wr_any;
    logic    en_bad;
    mem_op_e op;
    rd_any = |rden;
    wr_any = |wren;
    en_bad = (rd_any && (rden != MEM_BE_WORD)) || (wr_any && (wren != MEM_BE_WORD));
    op     = OP_NONE;
    if (en_bad || (rd_any && wr_any) || ((rd_any || wr_any) && (addr_lo != 2'b00))) begin
      op = OP_FAULT;
    end else if (rd_any) begin
      op = OP_LOAD;
    end else if (wr_any) begin
      op = OP_STORE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory/writeback stage: issues req/ack data-memory accesses, stalls execute
// while one is outstanding, and produces a one-cycle register-file writeback.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_x_rd_vld,
  input  logic [31:0] ex_x_rd,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_memaddr,
  input  logic [3:0]  ex_memrden,
  input  logic [3:0]  ex_memwren,
  input  logic [31:0] ex_memwrdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_vld,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_stall,
  output logic        error
);

  mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic               wb_vld_q, wb_vld_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               err_q, err_d;
  mem_op_e            op;
  logic               timed_out;

  assign op        = decode_op(ex_memrden, ex_memwren, ex_memaddr[1:0]);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wb_vld_d  = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;

    case (state_q)
      MEM_IDLE: begin
        case (op)
          OP_LOAD, OP_STORE: begin
            state_d = MEM_ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = (op == OP_STORE);
            addr_d  = ex_memaddr;
            be_d    = MEM_BE_WORD;
            rd_d    = ex_rd;
            if (op == OP_STORE) begin
              wdata_d = ex_memwrdata;
            end
          end
          OP_FAULT: begin
            err_d = 1'b1;
          end
          default: begin
            // x0 is hardwired to zero, so a write to it is suppressed.
            if (ex_x_rd_vld && (ex_rd != 5'd0)) begin
              wb_vld_d  = 1'b1;
              wb_rd_d   = ex_rd;
              wb_data_d = ex_x_rd;
            end
          end
        endcase
      end

      MEM_ACCESS: begin
        if (dm_ack) begin
          state_d = MEM_IDLE;
          req_d   = 1'b0;
          if (!we_q && (rd_q != 5'd0)) begin
            wb_vld_d  = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = dm_rdata;
          end
        end else if (timed_out) begin
          // Ack has priority above; an abort only happens with no ack this cycle.
          state_d = MEM_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = MEM_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wb_vld_q  <= wb_vld_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign dm_req    = req_q;
  assign dm_we     = we_q;
  assign dm_addr   = addr_q;
  assign dm_be     = be_q;
  assign dm_wdata  = wdata_q;
  assign wb_vld    = wb_vld_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign mem_stall = (state_q == MEM_ACCESS);
  assign error     = err_q;

endmodule
